// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - Banked main-memory request/response bus
// Master side issues pipelined requests; slave side is the banked memory.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_stall;

  modport master (
    output mem_addr, mem_wr, mem_rd, mem_data_in,
    input  mem_data_out, mem_stall
  );

  modport slave (
    input  mem_addr, mem_wr, mem_rd, mem_data_in,
    output mem_data_out, mem_stall
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - Cache line fill / victim write-back initiator
// Optional macro CRITICAL_WORD_FIRST_EN starts the read burst at the missed word.
module cache_fill_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_i,
  input  logic              dirty_i,
  input  logic [4:0]        tag_old_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  cache_fill_ctrl_if.master mem,
  output logic [2:0]        cache_offset_o,
  output logic              cache_wr_o,
  output logic [DATA_W-1:0] cache_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        w_q, w_d;
  logic [2:0]        rx_cnt_q, rx_cnt_d;
  logic [4:0]        tag_q, tag_d;
  logic [ADDR_W-4:0] line_q, line_d;
  logic [MEM_LAT-1:0] pipe_vld_q;
  logic [1:0]        pipe_word_q [MEM_LAT];

  logic       accept;
  logic       push;
  logic       ret_vld;
  logic [1:0] ret_word;
  logic [1:0] w_inc;
  logic [1:0] rd_start;
  logic [1:0] rd_start_in;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[2:0];

`ifdef CRITICAL_WORD_FIRST_EN
  logic [1:0] word_q, word_d;
  assign rd_start    = word_q;
  assign rd_start_in = addr_i[2:1];
`else
  assign rd_start    = 2'd0;
  assign rd_start_in = 2'd0;
`endif

  assign accept   = ((state_q == S_WB) || (state_q == S_RD)) && !mem.mem_stall;
  assign push     = (state_q == S_RD) && accept;
  assign ret_vld  = pipe_vld_q[MEM_LAT-1];
  assign ret_word = pipe_word_q[MEM_LAT-1];
  assign w_inc    = w_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    tag_d    = tag_q;
    line_d   = line_q;
    rx_cnt_d = rx_cnt_q + {2'b00, ret_vld};
`ifdef CRITICAL_WORD_FIRST_EN
    word_d   = word_q;
`endif
    case (state_q)
      S_IDLE: begin
        rx_cnt_d = 3'd0;
        if (miss_i) begin
          tag_d   = tag_old_i;
          line_d  = addr_i[ADDR_W-1:3];
          state_d = dirty_i ? S_WB : S_RD;
          w_d     = dirty_i ? 2'd0 : rd_start_in;
`ifdef CRITICAL_WORD_FIRST_EN
          word_d  = addr_i[2:1];
`endif
        end
      end
      S_WB: begin
        if (accept) begin
          w_d = w_inc;
          if (w_q == 2'd3) begin
            w_d     = rd_start;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (accept) begin
          w_d = w_inc;
          if (w_inc == rd_start) state_d = S_DRAIN;
        end
      end
      // The last word may be arriving this very cycle; leave DRAIN with it.
      S_DRAIN: begin
        if ((rx_cnt_q == 3'd4) || ((rx_cnt_q == 3'd3) && ret_vld)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        rx_cnt_d = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_q        <= 2'd0;
      rx_cnt_q   <= 3'd0;
      tag_q      <= 5'd0;
      line_q     <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_word_q[i] <= 2'd0;
`ifdef CRITICAL_WORD_FIRST_EN
      word_q     <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      rx_cnt_q       <= rx_cnt_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      pipe_vld_q[0]  <= push;
      pipe_word_q[0] <= w_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_word_q[i] <= pipe_word_q[i-1];
      end
`ifdef CRITICAL_WORD_FIRST_EN
      word_q         <= word_d;
`endif
    end
  end

  always_comb begin
    mem.mem_wr      = (state_q == S_WB);
    mem.mem_rd      = (state_q == S_RD);
    mem.mem_addr    = '0;
    mem.mem_data_in = '0;
    if (state_q == S_WB) begin
      mem.mem_addr    = ADDR_W'({tag_q, line_q[7:0], w_q, 1'b0});
      mem.mem_data_in = wb_data_i;
    end else if (state_q == S_RD) begin
      mem.mem_addr = {line_q, w_q, 1'b0};
    end
  end

  always_comb begin
    cache_wr_o     = ret_vld;
    cache_data_o   = ret_vld ? mem.mem_data_out : '0;
    cache_offset_o = 3'd0;
    if (ret_vld)               cache_offset_o = {ret_word, 1'b0};
    else if (state_q == S_WB)  cache_offset_o = {w_q, 1'b0};
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - Directed vector bench for cache_fill_ctrl
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        miss, dirty, stall;
  logic [4:0]  tag_old;
  logic [15:0] addr, wb_data, cdata;
  logic [2:0]  coff;
  logic        cwr, busy, done;

  logic        miss4;
  logic [15:0] wb_data4, cdata4;
  logic [2:0]  coff4;
  logic        cwr4, busy4, done4;

  cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif ();
  cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif4 ();

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .miss_i(miss), .dirty_i(dirty), .tag_old_i(tag_old),
    .addr_i(addr), .wb_data_i(wb_data), .mem(mif), .cache_offset_o(coff),
    .cache_wr_o(cwr), .cache_data_o(cdata), .busy_o(busy), .done_o(done)
  );

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .miss_i(miss4), .dirty_i(1'b0), .tag_old_i(5'd0),
    .addr_i(16'h3000), .wb_data_i(wb_data4), .mem(mif4), .cache_offset_o(coff4),
    .cache_wr_o(cwr4), .cache_data_o(cdata4), .busy_o(busy4), .done_o(done4)
  );

  // Memory responders: data = accepted read address ^ A5A5, MEM_LAT cycles later.
  logic [15:0] hist2 [2];
  logic [15:0] hist4 [4];
  always @(posedge clk) begin
    hist2[1] <= hist2[0];
    hist2[0] <= (mif.mem_rd && !mif.mem_stall) ? mif.mem_addr : 16'h0;
    for (int i = 3; i > 0; i--) hist4[i] <= hist4[i-1];
    hist4[0] <= (mif4.mem_rd && !mif4.mem_stall) ? mif4.mem_addr : 16'h0;
  end
  assign mif.mem_data_out  = hist2[1] ^ 16'hA5A5;
  assign mif.mem_stall     = stall;
  assign mif4.mem_data_out = hist4[3] ^ 16'hA5A5;
  assign mif4.mem_stall    = 1'b0;
  assign wb_data  = 16'hB000 | {13'd0, coff};
  assign wb_data4 = 16'hB000 | {13'd0, coff4};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic rd, input logic wr, input logic [15:0] maddr,
                                       input logic [15:0] mdin, input logic cw, input logic [2:0] co,
                                       input logic [15:0] cd, input logic dn, input logic bs);
    return {8'd0, rd, wr, maddr, mdin, cw, co, cd, dn, bs};
  endfunction

  function automatic logic [63:0] act1();
    return pack(mif.mem_rd, mif.mem_wr, mif.mem_addr, mif.mem_data_in, cwr,
                (cwr || mif.mem_wr) ? coff : 3'd0, cdata, done, busy);
  endfunction

  function automatic logic [63:0] act4();
    return pack(mif4.mem_rd, mif4.mem_wr, mif4.mem_addr, mif4.mem_data_in, cwr4,
                cwr4 ? coff4 : 3'd0, cdata4, done4, busy4);
  endfunction

  typedef struct {
    logic        miss;
    logic        dirty;
    logic [4:0]  tag;
    logic [15:0] addr;
    logic        stall;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic m, input logic d, input logic [4:0] t, input logic [15:0] a,
                     input logic s, input logic rd, input logic wr, input logic [15:0] maddr,
                     input logic cw, input logic [2:0] co, input logic dn, input logic bs,
                     input logic [15:0] base);
    vec_t v;
    v.miss = m; v.dirty = d; v.tag = t; v.addr = a; v.stall = s;
    v.exp = pack(rd, wr, maddr, wr ? (16'hB000 | {13'd0, co}) : 16'h0, cw,
                 (cw || wr) ? co : 3'd0, cw ? ((base | {13'd0, co}) ^ 16'hA5A5) : 16'h0, dn, bs);
    vecs.push_back(v);
  endtask

  int st;
  int bad;

  initial begin
    miss = 0; dirty = 0; tag_old = 0; addr = 0; stall = 0; miss4 = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    st = 2;
`else
    st = 0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", act1(), 64'd0);
    chk("reset_outputs_lat4", act4(), 64'd0);
    @(negedge clk);
    rst = 0;

    // Clean miss at 0x1234: row c is cycle c, miss sampled at edge 0.
    add(1, 0, 5'd0, 16'h1234, 0, 0, 0, 16'h0, 0, 3'd0, 0, 0, 16'h1230);
    for (int c = 1; c <= 8; c++) begin
      logic r, w;
      r = (c >= 1) && (c <= 4);
      w = (c >= 3) && (c <= 6);
      add(0, 0, 5'd0, 16'h0, 0, r, 0, r ? 16'h1230 + 16'(2 * ((st + c - 1) % 4)) : 16'h0,
          w, w ? 3'(2 * ((st + c - 3) % 4)) : 3'd0, c == 7, c <= 7, 16'h1230);
    end

    // Dirty miss: tag 0x1F, addr 0x0048.
    add(1, 1, 5'h1F, 16'h0048, 0, 0, 0, 16'h0, 0, 3'd0, 0, 0, 16'h0048);
    for (int c = 1; c <= 12; c++) begin
      logic r, w, cw;
      w  = (c <= 4);
      r  = (c >= 5) && (c <= 8);
      cw = (c >= 7) && (c <= 10);
      add(0, 0, 5'd0, 16'h0, 0, r, w,
          w ? 16'hF848 + 16'(2 * (c - 1)) : (r ? 16'h0048 + 16'(2 * (c - 5)) : 16'h0),
          cw, w ? 3'(2 * (c - 1)) : (cw ? 3'(2 * (c - 7)) : 3'd0), c == 11, c <= 11, 16'h0048);
    end

    // Stall on the 2nd read for 3 cycles, ignored misses while busy and in DONE, then a new fill.
    add(1, 0, 5'd0, 16'h1230, 0, 0, 0, 16'h0,    0, 3'd0, 0, 0, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    0, 1, 0, 16'h1230, 0, 3'd0, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    1, 1, 0, 16'h1232, 0, 3'd0, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    1, 1, 0, 16'h1232, 1, 3'd0, 0, 1, 16'h1230);
    add(1, 1, 5'h03, 16'h4000, 1, 1, 0, 16'h1232, 0, 3'd0, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    0, 1, 0, 16'h1232, 0, 3'd0, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    0, 1, 0, 16'h1234, 0, 3'd0, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    0, 1, 0, 16'h1236, 1, 3'd2, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    0, 0, 0, 16'h0,    1, 3'd4, 0, 1, 16'h1230);
    add(0, 0, 5'd0, 16'h0,    0, 0, 0, 16'h0,    1, 3'd6, 0, 1, 16'h1230);
    add(1, 1, 5'h03, 16'h4000, 0, 0, 0, 16'h0,   0, 3'd0, 1, 1, 16'h1230);
    add(1, 0, 5'd0, 16'h2000, 0, 0, 0, 16'h0,    0, 3'd0, 0, 0, 16'h2000);
    add(0, 0, 5'd0, 16'h0,    0, 1, 0, 16'h2000, 0, 3'd0, 0, 1, 16'h2000);

    foreach (vecs[i]) begin
      @(negedge clk);
      miss = vecs[i].miss; dirty = vecs[i].dirty; tag_old = vecs[i].tag;
      addr = vecs[i].addr; stall = vecs[i].stall;
      #1;
      chk($sformatf("vec%0d", i), act1(), vecs[i].exp);
    end
    miss = 0; dirty = 0; stall = 0;

    // Asynchronous reset mid-cycle while word 0 of the 0x2000 fill is being written.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_cache_wr", {47'd0, cwr, cdata}, {47'd0, 1'b1, 16'h2000 ^ 16'hA5A5});
    #2 rst = 1;
    #1;
    chk("async_rst_outputs", act1(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (cwr || busy || mif.mem_rd || mif.mem_wr) bad++;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);

    // MEM_LAT = 4 with miss held high: fills start every 10 cycles, three fills.
    @(negedge clk);
    miss4 = 1;
    for (int c = 1; c <= 34; c++) begin
      int  m;
      logic inf, erd, ecw;
      @(negedge clk);
      if (c == 30) miss4 = 0;
      #1;
      m   = c % 10;
      inf = (c < 30);
      erd = inf && (m >= 1) && (m <= 4);
      ecw = inf && (m >= 5) && (m <= 8);
      chk($sformatf("lat4_cyc%0d", c), act4(),
          pack(erd, 1'b0, erd ? 16'h3000 + 16'(2 * (m - 1)) : 16'h0, 16'h0, ecw,
               ecw ? 3'(2 * (m - 5)) : 3'd0,
               ecw ? ((16'h3000 | 16'(2 * (m - 5))) ^ 16'hA5A5) : 16'h0,
               inf && (m == 9), inf && (m != 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
